clk_div_sched: RTL and testbench

CLK_DIV_SCHED -- requirements
Module: clk_div_sched

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_chan.sv | 84 ++++++++
 rtl/clk_div_sched.sv | 98 +++++++++
 tb/tb_clk_div_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared defaults and config-FSM encoding for the clock divider scheduler.
package clk_div_pkg;

    localparam int NUM_CH_DEF       = 4;
    localparam int CNT_W_DEF        = 8;
    localparam int DEFAULT_HALF_DEF = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: half-period counter, output toggle and rising-edge tick.
// A new half/enable is only taken at a point where a fresh high phase starts,
// so a running half-period is never cut short or stretched.
module clk_div_chan #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_i,
    input  logic             apply_i,
    input  logic [CNT_W-1:0] apply_half_i,
    input  logic             apply_en_i,
    output logic             en_o,
    output logic             rise_o,
    output logic             clk_out_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             en_q, en_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             at_top;

    assign at_top    = (cnt_q == half_q);
    // The output goes 0->1 on the coming edge if counting normally.
    assign rise_o    = en_q && !clk_q && at_top;
    assign en_o      = en_q;
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

    // Next-state: forced sync, then config apply, then normal counting.
    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        en_d   = en_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (sync_i) begin
            cnt_d = '0;
            clk_d = 1'b1;
            if (apply_i) begin
                half_d = apply_half_i;
                en_d   = apply_en_i;
            end
        end else if (apply_i) begin
            // Applied either on a genuine rising edge (tick it) or while disabled.
            half_d = apply_half_i;
            en_d   = apply_en_i;
            cnt_d  = '0;
            clk_d  = 1'b1;
            tick_d = rise_o;
        end else if (!en_q) begin
            cnt_d = '0;
            clk_d = 1'b1;
        end else if (at_top) begin
            cnt_d  = '0;
            clk_d  = !clk_q;
            tick_d = !clk_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel state registers with synchronous reset to the divide-by-default state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            half_q <= CNT_W'(DEFAULT_HALF);
            en_q   <= 1'b1;
            clk_q  <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
            en_q   <= en_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Multi-channel clock divider with a single-slot config scheduler that
// defers each reconfiguration to the target channel's next rising edge.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]          cfg_half,
    input  logic                      cfg_en,
    input  logic                      sync_req,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH-1:0]         tick
);

    localparam int CH_W = $clog2(NUM_CH);

    cfg_state_e        state_q, state_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [CNT_W-1:0]  pend_half_q, pend_half_d;
    logic              pend_en_q, pend_en_d;
    logic              apply_now;
    logic              ch_ok;
    logic [NUM_CH-1:0] chan_en;
    logic [NUM_CH-1:0] chan_rise;

    // Out-of-range channel numbers are consumed but never scheduled.
    assign ch_ok = (int'(cfg_ch) < NUM_CH);

    // Config FSM: accept into the slot in IDLE, release it in WAIT.
    always_comb begin
        state_d     = state_q;
        pend_ch_d   = pend_ch_q;
        pend_half_d = pend_half_q;
        pend_en_d   = pend_en_q;
        apply_now   = 1'b0;
        cfg_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid && ch_ok) begin
                    pend_ch_d   = cfg_ch;
                    pend_half_d = cfg_half;
                    pend_en_d   = cfg_en;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // A sync realigns everything anyway, so the slot drains with it.
                if (sync_req || !chan_en[pend_ch_q] || chan_rise[pend_ch_q]) begin
                    apply_now = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and pending slot; reset drops any pending request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_ch_q   <= '0;
            pend_half_q <= '0;
            pend_en_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_ch_q   <= pend_ch_d;
            pend_half_q <= pend_half_d;
            pend_en_q   <= pend_en_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
        clk_div_chan #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_chan (
            .clk          (clk),
            .reset        (reset),
            .sync_i       (sync_req),
            .apply_i      (apply_now && (int'(pend_ch_q) == gi)),
            .apply_half_i (pend_half_q),
            .apply_en_i   (pend_en_q),
            .en_o         (chan_en[gi]),
            .rise_o       (chan_rise[gi]),
            .clk_out_o    (clk_out[gi]),
            .tick_o       (tick[gi])
        );
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched with an arithmetic reference model.
`timescale 1ns/1ps
module tb_clk_div_sched;

    localparam int NUM_CH       = 4;
    localparam int CNT_W        = 8;
    localparam int DEFAULT_HALF = 0;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             cfg_valid = 1'b0;
    logic [1:0]       cfg_ch    = '0;
    logic [CNT_W-1:0] cfg_half  = '0;
    logic             cfg_en    = 1'b0;
    logic             sync_req  = 1'b0;
    logic             cfg_ready;
    logic [3:0]       clk_out;
    logic [3:0]       tick;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    clk_div_sched #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_half  (cfg_half),
        .cfg_en    (cfg_en),
        .sync_req  (sync_req),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    // Reference model: each enabled channel is a square wave anchored at the
    // cycle t0 of its last realignment (reset, sync or applied config).
    int cyc = 0;
    int m_t0    [NUM_CH];
    int m_half  [NUM_CH];
    bit m_en    [NUM_CH];
    bit m_tick0 [NUM_CH];
    bit m_wait  = 1'b0;
    int m_pch   = 0;
    int m_phalf = 0;
    bit m_pen   = 1'b0;

    function automatic bit m_lvl(int i, int t);
        if (!m_en[i]) return 1'b1;
        return (((t - m_t0[i]) / (m_half[i] + 1)) % 2) == 0;
    endfunction

    function automatic bit m_tck(int i, int t);
        if (t == m_t0[i]) return m_tick0[i];
        if (!m_en[i]) return 1'b0;
        return ((t - m_t0[i]) % (2 * (m_half[i] + 1))) == 0;
    endfunction

    task automatic model_step();
        int t;
        bit apply;
        bit rise;
        t     = cyc + 1;
        apply = 1'b0;
        rise  = 1'b0;
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_t0[i] = t; m_half[i] = DEFAULT_HALF; m_en[i] = 1'b1; m_tick0[i] = 1'b0;
            end
            m_wait = 1'b0;
        end else begin
            if (m_wait) begin
                rise  = m_en[m_pch] && !m_lvl(m_pch, t - 1) && m_lvl(m_pch, t);
                apply = sync_req || !m_en[m_pch] || rise;
            end
            if (sync_req) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    m_t0[i] = t; m_tick0[i] = 1'b0;
                end
            end
            if (apply) begin
                m_half[m_pch]  = m_phalf;
                m_en[m_pch]    = m_pen;
                m_t0[m_pch]    = t;
                m_tick0[m_pch] = rise && !sync_req;
                m_wait         = 1'b0;
            end else if (!m_wait && cfg_valid && (int'(cfg_ch) < NUM_CH)) begin
                m_pch   = int'(cfg_ch);
                m_phalf = int'(cfg_half);
                m_pen   = cfg_en;
                m_wait  = 1'b1;
            end
        end
        cyc = t;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h, required %0h", name, cyc, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Every cycle: DUT outputs against the model.
    initial begin
        logic [3:0] e_clk;
        logic [3:0] e_tick;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    e_clk[i]  = m_lvl(i, cyc);
                    e_tick[i] = m_tck(i, cyc);
                end
                check("model_clk_out", 32'(clk_out), 32'(e_clk));
                check("model_tick", 32'(tick), 32'(e_tick));
                check("model_cfg_ready", 32'(cfg_ready), 32'(!m_wait));
            end
        end
    end

    task automatic do_cfg(input logic [1:0] ch, input logic [CNT_W-1:0] h, input logic en);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_half = h; cfg_en = en;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (!cfg_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_clk_out", 32'(clk_out), 32'hF);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        reset = 1'b0;

        // Default divide-by-2 on all channels
        @(negedge clk); check("div2_low", 32'(clk_out), 32'h0); check("div2_low_tick", 32'(tick), 32'h0);
        @(negedge clk); check("div2_high", 32'(clk_out), 32'hF); check("div2_tick", 32'(tick), 32'hF);
        @(negedge clk); check("div2_low2", 32'(clk_out), 32'h0);

        // ch1 half=1 requested while ch1 is low: waits for its next rise
        do_cfg(2'd1, 8'd1, 1'b1);
        check("c1_wait_ready", 32'(cfg_ready), 32'h0);
        @(negedge clk); check("c1_still_wait", 32'(cfg_ready), 32'h0); check("c1_n5", 32'(clk_out), 32'h0);
        @(negedge clk); check("c1_applied", 32'(cfg_ready), 32'h1); check("c1_n6", 32'(clk_out), 32'hF);
        @(negedge clk); check("c1_n7", 32'(clk_out), 32'b0010); check("c1_n7_tick", 32'(tick), 32'h0);
        @(negedge clk); check("c1_n8", 32'(clk_out), 32'b1101); check("c1_n8_tick", 32'(tick), 32'b1101);
        @(negedge clk); check("c1_n9", 32'(clk_out), 32'h0);
        @(negedge clk); check("c1_n10", 32'(clk_out), 32'hF); check("c1_n10_tick", 32'(tick), 32'hF);

        // ch2 disabled at its next rise, then re-enabled at half=3
        do_cfg(2'd2, 8'd0, 1'b0);
        check("c2_n11", 32'(clk_out), 32'b0010);
        @(negedge clk); check("c2_n12", 32'(clk_out), 32'b1101); check("c2_n12_tick", 32'(tick), 32'b1101);
        @(negedge clk); check("c2_held", 32'(clk_out), 32'b0100); check("c2_n13_tick", 32'(tick), 32'h0);
        @(negedge clk); check("c2_n14_tick", 32'(tick), 32'b1011);
        do_cfg(2'd2, 8'd3, 1'b1);
        check("c2_n15", 32'(clk_out), 32'b0110);
        @(negedge clk); check("c2_n16", 32'(clk_out), 32'b1101); check("c2_n16_tick", 32'(tick), 32'b1001);
        repeat (4) @(negedge clk); check("c2_low_phase", 32'(clk_out[2]), 32'h0);
        repeat (4) @(negedge clk); check("c2_period8_tick", 32'(tick[2]), 32'h1);

        // ch0 half=3, ch3 half=1, then sync realigns every channel
        do_cfg(2'd0, 8'd3, 1'b1); wait_ready("c0_apply_ready");
        do_cfg(2'd3, 8'd1, 1'b1); wait_ready("c3_apply_ready");
        sync_req = 1'b1;
        @(negedge clk);
        sync_req = 1'b0;
        check("sync_clk_out", 32'(clk_out), 32'hF); check("sync_no_tick", 32'(tick), 32'h0);
        repeat (4) @(negedge clk); check("sync_p4", 32'(clk_out), 32'b1010); check("sync_p4_tick", 32'(tick), 32'b1010);
        repeat (4) @(negedge clk); check("sync_p8", 32'(clk_out), 32'hF); check("sync_p8_tick", 32'(tick), 32'hF);

        // cfg_valid held through WAIT with a different channel
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_half = 8'd1; cfg_en = 1'b1;
        @(negedge clk);
        check("hold_first_accepted", 32'(cfg_ready), 32'h0);
        cfg_ch = 2'd3; cfg_half = 8'd2;
        wait_ready("hold_first_done");
        @(negedge clk);
        cfg_valid = 1'b0;
        check("hold_second_accepted", 32'(cfg_ready), 32'h0);
        // sync while pending: slot drains in the same cycle
        sync_req = 1'b1;
        @(negedge clk);
        sync_req = 1'b0;
        check("sync_in_wait_ready", 32'(cfg_ready), 32'h1);
        check("sync_in_wait_clk", 32'(clk_out), 32'hF);
        repeat (3) @(negedge clk); check("no_requeue", 32'(cfg_ready), 32'h1);

        // reset in WAIT discards the pending config
        do_cfg(2'd2, 8'd7, 1'b1);
        check("rw_pending", 32'(cfg_ready), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check("rw_clk_out", 32'(clk_out), 32'hF); check("rw_tick", 32'(tick), 32'h0);
        check("rw_ready", 32'(cfg_ready), 32'h1);
        reset = 1'b0;
        @(negedge clk); check("rw_div2_low", 32'(clk_out), 32'h0);
        @(negedge clk); check("rw_div2_high", 32'(clk_out), 32'hF); check("rw_div2_tick", 32'(tick), 32'hF);
        @(negedge clk); check("rw_idle", 32'(cfg_ready), 32'h1); check("rw_div2_low2", 32'(clk_out), 32'h0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
